// File: rtl/dna_reader_if.sv
// Pin bundle between the DNA reader controller and the DNA_PORT primitive.
// The master is the controller, and the slave is the primitive or its wrapper.
interface dna_reader_if;
  logic dna_clk;
  logic dna_read;
  logic dna_shift;
  logic dna_din;
  logic dna_dout;

  modport master (
    output dna_clk,
    output dna_read,
    output dna_shift,
    output dna_din,
    input  dna_dout
  );

  modport slave (
    input  dna_clk,
    input  dna_read,
    input  dna_shift,
    input  dna_din,
    output dna_dout
  );
endinterface

// File: rtl/dna_reader.sv
// Drives a DNA_PORT with a divided clock to load and shift out the device DNA.
// The full value is then held in a parallel register.
module dna_reader #(
  parameter int DNA_WIDTH  = 57,
  parameter int CLK_DIV    = 4,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 valid,
  output logic [DNA_WIDTH-1:0] dna_value,
  dna_reader_if.master         dna
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = $clog2(DNA_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DNA_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    FINISH
  } state_t;

  state_t               state, state_n;
  logic [DIV_W-1:0]     div, div_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [DNA_WIDTH-1:0] sreg, sreg_n;
  logic [DNA_WIDTH-1:0] value_n;
  logic                 pending, pending_n;
  logic                 busy_n, done_n, valid_n;
  logic                 dclk_n, read_n, shift_n;
  logic                 tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      div           <= '0;
      cnt           <= '0;
      sreg          <= '0;
      pending       <= AUTO_START;
      busy          <= 1'b0;
      done          <= 1'b0;
      valid         <= 1'b0;
      dna_value     <= '0;
      dna.dna_clk   <= 1'b0;
      dna.dna_read  <= 1'b0;
      dna.dna_shift <= 1'b0;
      dna.dna_din   <= 1'b0;
    end else begin
      state         <= state_n;
      div           <= div_n;
      cnt           <= cnt_n;
      sreg          <= sreg_n;
      pending       <= pending_n;
      busy          <= busy_n;
      done          <= done_n;
      valid         <= valid_n;
      dna_value     <= value_n;
      dna.dna_clk   <= dclk_n;
      dna.dna_read  <= read_n;
      dna.dna_shift <= shift_n;
      dna.dna_din   <= 1'b0;
    end
  end

  // The edge entering FINISH publishes the result, so DONE is high in the FINISH cycle.
  always_comb begin
    state_n   = state;
    div_n     = div;
    cnt_n     = cnt;
    sreg_n    = sreg;
    pending_n = pending;
    busy_n    = busy;
    done_n    = 1'b0;
    valid_n   = valid;
    value_n   = dna_value;
    dclk_n    = dna.dna_clk;
    read_n    = dna.dna_read;
    shift_n   = dna.dna_shift;
    tick      = (div == DIV_LAST);

    case (state)
      IDLE: begin
        dclk_n = 1'b0;
        if (start || pending) begin
          state_n   = LOAD;
          busy_n    = 1'b1;
          read_n    = 1'b1;
          div_n     = '0;
          cnt_n     = '0;
          pending_n = 1'b0;
        end
      end

      LOAD: begin
        if (tick) begin
          div_n = '0;
          if (dna.dna_clk) begin
            dclk_n  = 1'b0;
            read_n  = 1'b0;
            shift_n = 1'b1;
            state_n = SHIFT;
          end else begin
            dclk_n = 1'b1;
          end
        end else begin
          div_n = div + DIV_W'(1);
        end
      end

      SHIFT: begin
        if (tick) begin
          div_n = '0;
          if (dna.dna_clk) begin
            dclk_n = 1'b0;
            if (cnt == CNT_LAST) begin
              shift_n = 1'b0;
              state_n = FINISH;
              value_n = sreg;
              valid_n = 1'b1;
              done_n  = 1'b1;
              busy_n  = 1'b0;
            end
          end else begin
            dclk_n = 1'b1;
            sreg_n = {sreg[DNA_WIDTH-2:0], dna.dna_dout};
            cnt_n  = cnt + CNT_W'(1);
          end
        end else begin
          div_n = div + DIV_W'(1);
        end
      end

      FINISH: begin
        dclk_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dna_reader.sv
// Directed bench for dna_reader with behavioural DNA_PORT models.
// One instance uses CLK_DIV=4 without auto start, and the other uses CLK_DIV=1 with auto start.
module tb_dna_reader;
  localparam int W = 57;

  logic         clk;
  logic         rstA, rstB, startA, startB;
  logic         busyA, doneA, validA, busyB, doneB, validB;
  logic [W-1:0] valueA, valueB;
  logic [W-1:0] simA, simB, modelA, modelB;
  int           checks, errors;
  int           doneCntA, doneCntB, riseB;
  int           edges, snap, snapRise;

  dna_reader_if ifA ();
  dna_reader_if ifB ();

  dna_reader #(.DNA_WIDTH(W), .CLK_DIV(4), .AUTO_START(1'b0)) u_dutA (
    .clk(clk), .rst_n(rstA), .start(startA), .busy(busyA), .done(doneA),
    .valid(validA), .dna_value(valueA), .dna(ifA)
  );

  dna_reader #(.DNA_WIDTH(W), .CLK_DIV(1), .AUTO_START(1'b1)) u_dutB (
    .clk(clk), .rst_n(rstB), .start(startB), .busy(busyB), .done(doneB),
    .valid(validB), .dna_value(valueB), .dna(ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DNA_PORT behaviour: READ loads the value, SHIFT moves the next bit to DOUT.
  always @(posedge ifA.dna_clk) begin
    if (ifA.dna_read) modelA <= simA;
    else if (ifA.dna_shift) modelA <= {modelA[W-2:0], ifA.dna_din};
  end
  assign ifA.dna_dout = modelA[W-1];

  always @(posedge ifB.dna_clk) begin
    riseB <= riseB + 1;
    if (ifB.dna_read) modelB <= simB;
    else if (ifB.dna_shift) modelB <= {modelB[W-2:0], ifB.dna_din};
  end
  assign ifB.dna_dout = modelB[W-1];

  always @(negedge clk) begin
    if (doneA) doneCntA++;
    if (doneB) doneCntB++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit sel);
    @(negedge clk);
    if (sel) startB = 1'b1;
    else startA = 1'b1;
    @(posedge clk);
    #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic waitDone(input bit sel, output int count);
    count = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      if (sel ? doneB : doneA) begin
        count = n;
        break;
      end
    end
    if (count < 0) checkOutput("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    checks = 0; errors = 0; doneCntA = 0; doneCntB = 0; riseB = 0;
    startA = 1'b0; startB = 1'b0;
    simA = 57'h1A55A5A5A5A5A5A;
    simB = 57'h0000000000000001;
    modelA = '0; modelB = '0;
    rstA = 1'b1; rstB = 1'b1;
    #2;
    rstA = 1'b0; rstB = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", {63'd0, busyA}, 64'd0);
    checkOutput("rst_done", {63'd0, doneA}, 64'd0);
    checkOutput("rst_valid", {63'd0, validA}, 64'd0);
    checkOutput("rst_value", {7'd0, valueA}, 64'd0);
    checkOutput("rst_dclk", {63'd0, ifA.dna_clk}, 64'd0);
    checkOutput("rst_read", {63'd0, ifA.dna_read}, 64'd0);
    checkOutput("rst_shift", {63'd0, ifA.dna_shift}, 64'd0);
    checkOutput("rst_din", {63'd0, ifA.dna_din}, 64'd0);
    checkOutput("rst_busyB", {63'd0, busyB}, 64'd0);

    // Auto start on B: the first edge after release starts the read.
    @(negedge clk);
    rstA = 1'b1; rstB = 1'b1;
    waitDone(1'b1, edges);
    checkOutput("auto_edges", 64'(edges), 64'd117);
    checkOutput("auto_value", {7'd0, valueB}, 64'd1);
    checkOutput("auto_valid", {63'd0, validB}, 64'd1);
    checkOutput("auto_no_startA", {63'd0, busyA}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("auto_done_pulse", {63'd0, doneB}, 64'd0);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("auto_done_count", 64'(doneCntB), 64'd1);
    checkOutput("auto_idle", {63'd0, busyB}, 64'd0);

    // Basic read on A.
    snap = doneCntA;
    applyStimulus(1'b0);
    checkOutput("basic_busy", {63'd0, busyA}, 64'd1);
    checkOutput("basic_read", {63'd0, ifA.dna_read}, 64'd1);
    checkOutput("basic_shift", {63'd0, ifA.dna_shift}, 64'd0);
    waitDone(1'b0, edges);
    checkOutput("basic_edges", 64'(edges), 64'd464);
    checkOutput("basic_value", {7'd0, valueA}, {7'd0, 57'h1A55A5A5A5A5A5A});
    checkOutput("basic_valid", {63'd0, validA}, 64'd1);
    checkOutput("basic_busy_end", {63'd0, busyA}, 64'd0);
    @(posedge clk);
    #1;
    checkOutput("basic_done_pulse", {63'd0, doneA}, 64'd0);
    checkOutput("basic_done_count", 64'(doneCntA - snap), 64'd1);

    // Re-read with START pulses while busy and in the DONE cycle.
    simA = 57'h0AAAAAAAAAAAAAA;
    snap = doneCntA;
    applyStimulus(1'b0);
    edges = -1;
    for (int n = 1; n <= 2000; n++) begin
      @(posedge clk);
      #1;
      startA = (n == 10 || n == 200);
      if (n == 200) begin
        checkOutput("reread_hold", {7'd0, valueA}, {7'd0, 57'h1A55A5A5A5A5A5A});
        checkOutput("reread_valid", {63'd0, validA}, 64'd1);
      end
      if (doneA) begin
        edges = n;
        break;
      end
    end
    if (edges < 0) checkOutput("reread_timeout", 64'd0, 64'd1);
    startA = 1'b1;
    checkOutput("reread_edges", 64'(edges), 64'd464);
    checkOutput("reread_value", {7'd0, valueA}, {7'd0, 57'h0AAAAAAAAAAAAAA});
    @(posedge clk);
    #1;
    startA = 1'b0;
    checkOutput("done_cycle_start", {63'd0, busyA}, 64'd0);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("reread_idle", {63'd0, busyA}, 64'd0);
    checkOutput("reread_done_count", 64'(doneCntA - snap), 64'd1);

    // Reset in the middle of a read on A.
    applyStimulus(1'b0);
    repeat (149) @(posedge clk);
    #1;
    checkOutput("mid_dclk_high", {63'd0, ifA.dna_clk}, 64'd1);
    rstA = 1'b0;
    #1;
    checkOutput("mid_rst_dclk", {63'd0, ifA.dna_clk}, 64'd0);
    checkOutput("mid_rst_read", {63'd0, ifA.dna_read}, 64'd0);
    checkOutput("mid_rst_shift", {63'd0, ifA.dna_shift}, 64'd0);
    checkOutput("mid_rst_busy", {63'd0, busyA}, 64'd0);
    checkOutput("mid_rst_valid", {63'd0, validA}, 64'd0);
    checkOutput("mid_rst_value", {7'd0, valueA}, 64'd0);
    @(negedge clk);
    rstA = 1'b1;
    applyStimulus(1'b0);
    waitDone(1'b0, edges);
    checkOutput("after_rst_edges", 64'(edges), 64'd464);
    checkOutput("after_rst_value", {7'd0, valueA}, {7'd0, 57'h0AAAAAAAAAAAAAA});

    // Minimum divider on B: one load edge plus one edge per bit.
    simB = 57'h1FFFFFFFFFFFFFF;
    snapRise = riseB;
    applyStimulus(1'b1);
    waitDone(1'b1, edges);
    checkOutput("div1_edges", 64'(edges), 64'd116);
    checkOutput("div1_rises", 64'(riseB - snapRise), 64'd58);
    checkOutput("div1_value", {7'd0, valueB}, {7'd0, 57'h1FFFFFFFFFFFFFF});
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
